// File: rtl/pipe_rca_if.sv
// Operand/result handshake bundle for pipe_rca.
// The sub signal exists only when PIPE_RCA_SUB_EN is defined.
interface pipe_rca_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PIPE_RCA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef PIPE_RCA_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, co
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef PIPE_RCA_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, co
    );
endinterface

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder, one SEG_W-bit segment per stage, valid/ready flow control.
// Define PIPE_RCA_SUB_EN to add the sub input (a - b, co = no borrow).
module pipe_rca #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input logic       clk,
    input logic       rst,
    pipe_rca_if.slave bus
);
    localparam int STAGES = WIDTH / SEG_W;

    function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                               input logic [SEG_W-1:0] y,
                                               input logic             c);
        return {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, c};
    endfunction

    logic             en;
    logic             out_vld;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Subtraction folds into the first stage as a + ~b + 1.
`ifdef PIPE_RCA_SUB_EN
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub | bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    assign en            = bus.out_ready || !out_vld;
    assign bus.in_ready  = en;
    assign out_vld       = stg[STAGES-1].vld_p;
    assign bus.out_valid = out_vld;
    assign bus.sum       = stg[STAGES-1].res_p;
    assign bus.co        = stg[STAGES-1].cy_p;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = (k + 1) * SEG_W;
        localparam int HI = WIDTH - LO;

        logic             vld_p;
        logic             cy_p;
        logic             vi;
        logic             ci;
        logic [SEG_W-1:0] sa;
        logic [SEG_W-1:0] sb;
        logic [SEG_W:0]   s;
        logic [LO-1:0]    res_d;
        logic [LO-1:0]    res_p;

        if (k == 0) begin : g_src
            assign vi    = bus.in_valid;
            assign ci    = c_in;
            assign sa    = bus.a[SEG_W-1:0];
            assign sb    = b_in[SEG_W-1:0];
            assign res_d = s[SEG_W-1:0];
        end else begin : g_src
            assign vi    = stg[k-1].vld_p;
            assign ci    = stg[k-1].cy_p;
            assign sa    = stg[k-1].g_ops.a_p[SEG_W-1:0];
            assign sb    = stg[k-1].g_ops.b_p[SEG_W-1:0];
            assign res_d = {s[SEG_W-1:0], stg[k-1].res_p};
        end

        assign s = seg_add(sa, sb, ci);

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= 1'b0;
            end else if (en) begin
                vld_p <= vi;
            end
        end

        if (k == STAGES - 1) begin : g_last
            // Output data only moves on a valid beat so sum/co hold across bubbles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_p <= '0;
                    cy_p  <= 1'b0;
                end else if (en && vi) begin
                    res_p <= res_d;
                    cy_p  <= s[SEG_W];
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (en) begin
                    res_p <= res_d;
                    cy_p  <= s[SEG_W];
                end
            end
        end

        if (HI > 0) begin : g_ops
            logic [HI-1:0] a_p;
            logic [HI-1:0] b_p;
            if (k == 0) begin : g_in
                always_ff @(posedge clk) begin
                    if (en) begin
                        a_p <= bus.a[WIDTH-1:SEG_W];
                        b_p <= b_in[WIDTH-1:SEG_W];
                    end
                end
            end else begin : g_in
                always_ff @(posedge clk) begin
                    if (en) begin
                        a_p <= stg[k-1].g_ops.a_p[HI+SEG_W-1:SEG_W];
                        b_p <= stg[k-1].g_ops.b_p[HI+SEG_W-1:SEG_W];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_rca.sv
// Scoreboard bench for pipe_rca (WIDTH=16, SEG_W=4): directed cases, stall, reset, random traffic.
module tb_pipe_rca;
    localparam int WIDTH  = 16;
    localparam int SEG_W  = 4;
    localparam int STAGES = WIDTH / SEG_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_rca_if #(.WIDTH(WIDTH)) bif ();

    pipe_rca #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH:0]   expq[$];
    logic             cur_sub = 1'b0;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic             prev_rst = 1'b1;
    logic             prev_co = 1'b0;
    logic [WIDTH-1:0] prev_sum = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-precision integer sum, bit WIDTH is the carry out.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
        logic [31:0] r;
        if (s) r = 32'(x) + ((32'd1 << WIDTH) - 32'd1 - 32'(y)) + 32'd1;
        else   r = 32'(x) + 32'(y) + 32'(c);
        return r[WIDTH:0];
    endfunction

    task automatic set_in(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input logic ts);
        bif.a   = ta;
        bif.b   = tb_;
        bif.cin = tc;
        cur_sub = ts;
`ifdef PIPE_RCA_SUB_EN
        bif.sub = ts;
`endif
    endtask

    task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts);
        int n = 0;
        set_in(ta, tb_, tc, ts);
        bif.in_valid = 1'b1;
        @(negedge clk);
        while (!bif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bif.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bif.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!bif.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bif.out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: out_valid=0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Monitor: pops expected results on every output transfer, checks hold behaviour.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
        end else begin
            if (!prev_rst && prev_valid && !prev_ready)
                chk("stall_hold", {bif.out_valid, bif.co, bif.sum}, {1'b1, prev_co, prev_sum});
            else if (!prev_rst && !bif.out_valid)
                chk("idle_hold", {bif.co, bif.sum}, {prev_co, prev_sum});
            chk("in_ready", bif.in_ready, bif.out_ready || !bif.out_valid);
            if (bif.out_valid && bif.out_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%0h, expected no beat", {bif.co, bif.sum});
                end else begin
                    chk("result", {bif.co, bif.sum}, expq.pop_front());
                end
            end
            if (bif.in_valid && bif.in_ready)
                expq.push_back(model(bif.a, bif.b, bif.cin, cur_sub));
        end
        prev_rst   = rst;
        prev_valid = bif.out_valid;
        prev_ready = bif.out_ready;
        prev_co    = bif.co;
        prev_sum   = bif.sum;
    end

    initial begin
        int  cnt;
        logic acc;
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        set_in('0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", bif.out_valid, 1'b0);
        chk("reset_sum", bif.sum, 16'h0000);
        chk("reset_co", bif.co, 1'b0);
        chk("reset_in_ready", bif.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Full carry ripple through all segments, with latency measurement.
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        cnt = 1;
        @(negedge clk);
        while (!bif.out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", cnt, STAGES);
        chk("carry_chain", {bif.co, bif.sum}, 17'h1_0000);
        @(posedge clk);
        #1;

        drive(16'h1234, 16'h4321, 1'b1, 1'b0);
        idle(6);

        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drive(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_valid("b2b_first");
        @(negedge clk);
        chk("b2b_second_valid", bif.out_valid, 1'b1);
        @(negedge clk);
        chk("b2b_third_valid", bif.out_valid, 1'b1);
        @(posedge clk);
        #1;
        idle(4);

        // Fill the pipe, then stall the consumer with a beat waiting at the input.
        for (int i = 0; i < 6; i++)
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        bif.out_ready = 1'b0;
        set_in(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        bif.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", bif.out_valid, 1'b1);
            chk("stall_in_ready", bif.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", bif.in_ready, 1'b1);
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        @(negedge clk);
        chk("release_next_valid", bif.out_valid, 1'b1);
        @(posedge clk);
        #1;
        idle(8);

        // Reset with two beats in flight.
        drive(16'h00AA, 16'h0055, 1'b0, 1'b0);
        wait_valid("pre_reset");
        @(posedge clk);
        #1;
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        drive(16'h3333, 16'h4444, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", bif.out_valid, 1'b0);
        chk("midrst_sum", bif.sum, 16'h0000);
        chk("midrst_co", bif.co, 1'b0);
        @(posedge clk);
        #1;
        idle(10);

`ifdef PIPE_RCA_SUB_EN
        drive(16'h0005, 16'h0007, 1'b1, 1'b1);
        drive(16'h0007, 16'h0005, 1'b0, 1'b1);
        idle(8);
`endif

        // Random traffic with random back-pressure; beats are held until accepted.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = bif.in_valid && bif.in_ready;
            @(posedge clk);
            #1;
            if (acc || !bif.in_valid) begin
                bif.in_valid = ($urandom_range(0, 3) != 0);
`ifdef PIPE_RCA_SUB_EN
                set_in(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`else
                set_in(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
`endif
            end
            bif.out_ready = ($urandom_range(0, 3) != 0);
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        idle(20);
        chk("drain_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined ripple-carry adder with a valid/ready handshake. The WIDTH-bit operands are split into SEG_W-bit segments. Each pipeline stage ripples one segment and registers the carry into the next stage. Sits in the datapath library as the multi-bit successor to the 4-bit combinational full-adder chain, for use wherever wide additions must meet timing at one result per cycle.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG_W.
- SEG_W, 4, bits rippled per pipeline stage; STAGES = WIDTH/SEG_W (at least 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- co  output  1  carry out of bit WIDTH-1.

## Operation
- Stage k (k = 0..STAGES-1) holds the following registers:
  - a valid bit;
  - the low (k+1)*SEG_W result bits;
  - the unconsumed upper bits of A and B;
  - the carry out of segment k.
- Stage 0 adds a[SEG_W-1:0] + b[SEG_W-1:0] + cin. Stage k adds its segment plus the registered carry from stage k-1.
- The last stage drives sum, co and out_valid directly from registers. There is no combinational path from a/b to sum.
- Arithmetic is modulo 2^WIDTH; co is the true carry out.
- Global pipeline enable: en = out_ready || !out_valid.
  - When en=1, all stages shift by one and stage 0 captures {in_valid, a, b, cin}.
  - When en=0, all stage registers hold.
- in_ready = en, which is combinational from out_ready and out_valid.
- A transfer occurs on a cycle where in_valid && in_ready (input side) or out_valid && out_ready (output side).
- Bubbles (in_valid=0 while en=1) propagate as invalid stages. They are not compressed.
- Data registers of invalid stages are don't-care internally, but sum and co must hold their last value while out_valid=0.

## Timing
- Reset: all stage valid bits become 0 on the clock edge with rst=1. out_valid=0, sum=0, co=0 the cycle after. in_ready=1 while out_valid=0.
- Reset mid-operation discards every in-flight beat; no partial result ever appears.
- rst has priority over en.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1. For example, STAGES=4 gives the result 4 cycles after acceptance, counting the accept cycle.
- Throughput: one result per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - sum, co and out_valid are held stable;
  - in_ready=0 and the input beat is not captured;
  - the beat is captured on the first cycle out_ready returns high.
- Simultaneous output pop and input push in the same cycle is legal and lossless.
- SEG_W = WIDTH degenerates to a 1-stage registered adder with latency 1.

## Configuration
- PIPE_RCA_SUB_EN defined:
  - adds port sub (input, 1 bit), captured with the operands;
  - sub=1 computes a + ~b + 1 (cin ignored), and co=1 means no borrow (a >= b unsigned);
  - sub=0 behaves as plain add with cin.
- PIPE_RCA_SUB_EN undefined: port sub does not exist and the block is add-only.

## Test plan
All cases use WIDTH=16, SEG_W=4, out_ready=1 unless stated.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, co=1, out_valid 4 cycles after accept (full carry across all segments).
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, co=0.
- Three back-to-back beats (0x0001+0x0001, 0x00FF+0x0001, 0x8000+0x8000) -> results 0x0002/0, 0x0100/0, 0x0000/1 on consecutive cycles.
- Result pending with out_ready held low for 3 cycles and in_valid=1 -> sum/co stable, in_ready=0, no beat lost or duplicated; next beat emerges 1 cycle after the release.
- rst asserted for 1 cycle while 2 beats are in flight -> out_valid=0, sum=0, co=0 the next cycle; no stale result appears afterwards.
- With PIPE_RCA_SUB_EN, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, co=0; a=0x0007, b=0x0005 -> sum=0x0002, co=1.
